spi_axi_sequencer: RTL and testbench
====================================

SPI_AXI_SEQUENCER -- requirements
Module: spi_axi_sequencer

Interface
REQ-001 Parameters (name, default, meaning):
- BASE_ADDR, 32'h0000_0000: SPI AXI controller base address.
- OFF_CTRL, 8'h00: SPI_CTRL register offset.
- OFF_STATUS, 8'h04: SPI_STATUS register offset.
- OFF_ADDR, 8'h08: SPI_ADDR register offset.
- OFF_DIN, 8'h0C: SPI_DATA_IN register offset.
- OFF_DOUT, 8'h10: SPI_DATA_OUT register offset.
- DONE_BIT, 0: bit index of SPI_STATUS that reads 1 when a transaction is complete.
REQ-002 Clock and reset (name, direction, width, meaning):
- aclk, in, 1: single clock.
- aresetn, in, 1: asynchronous, active-low reset.
REQ-003 Command port:
- cmd_valid, in, 1: command request.
- cmd_ready, out, 1: command accepted.
- cmd_rw, in, 1: 1 = read, 0 = write.
- cmd_addr, in, 6: MFRC522 register address.
- cmd_wdata, in, 8: write byte.
REQ-004 Response port:
- rsp_valid, out, 1: response available.
- rsp_ready, in, 1: response taken.
- rsp_rdata, out, 8: read byte.
- rsp_err, out, 1: AXI error or timeout.
REQ-005 AXI4 master ports; widths as for the SPI AXI controller slave.
- Write address: m_axi_aw{id,addr,len,size,burst,cache,prot,valid}, awready in.
- Write data: m_axi_w{data,strb,last,valid}, wready in.
- Write response: m_axi_b{id,resp,valid} in, bready out.
- Read address: m_axi_ar{id,addr,len,size,burst,cache,prot,valid}, arready in.
- Read data: m_axi_r{id,data,resp,last,valid} in, rready out.

Function
REQ-006 All transfers SHALL be single-beat: id=0, len=0, size=2, burst=INCR, cache=0, prot=0, wstrb=4'hF, wlast=1.
REQ-007 cmd_ready SHALL be 1 only in IDLE; the command is captured on cmd_valid&cmd_ready.
REQ-008 State sequence after capture: WR_ADDR -> (write only) WR_DIN -> WR_CTRL -> POLL -> (read only) RD_DOUT -> RSP -> IDLE.
REQ-009 Register write step:
- awvalid and wvalid SHALL assert in the same cycle.
- Each SHALL drop independently on its own handshake.
- bready SHALL be 1 from then until bvalid; the step completes on the B handshake.
REQ-010 Register read step: arvalid held until arready, then rready=1 until the rvalid handshake.
REQ-011 Write data per step:
- WR_ADDR: {26'b0,cmd_addr}.
- WR_DIN: {24'b0,cmd_wdata}.
- WR_CTRL: 32'h0000_0101 | (cmd_rw<<1), i.e. num_bytes=1 in [15:8], rw in bit1, enable in bit0.
REQ-012 POLL SHALL read SPI_STATUS repeatedly, with no idle cycle between reads, until rdata[DONE_BIT]=1.
REQ-013 RD_DOUT SHALL capture rdata[7:0] into rsp_rdata. rsp_rdata SHALL be 8'h00 for write commands.
REQ-014 Any bresp or rresp != 2'b00 SHALL set rsp_err=1 and jump directly to RSP, abandoning the remaining steps.
REQ-015 In RSP, rsp_valid=1 and rsp_rdata/rsp_err SHALL hold stable until rsp_ready; the state then returns to IDLE.
REQ-016 At most one AXI address request SHALL be outstanding at any time; AR and AW SHALL never be active together.

Reset
REQ-017 aresetn=0 SHALL asynchronously force IDLE and clear all valid/ready outputs, rsp_rdata, rsp_err and all counters to 0.
REQ-018 A reset mid-sequence SHALL abandon the command without issuing a response.

Configuration
REQ-019 With SPI_SEQ_TIMEOUT_EN defined:
- A 10-bit poll counter SHALL count STATUS reads within a command.
- The 1024th read without DONE SHALL end polling with rsp_err=1 and go to RSP, skipping RD_DOUT.
REQ-020 Without SPI_SEQ_TIMEOUT_EN: no counter; POLL waits indefinitely.

Verification
REQ-021 Write cmd addr=0x0C, wdata=0x10; DONE on 3rd poll:
- AXI writes in order ADDR=0x0C, DIN=0x10, CTRL=0x101.
- 3 STATUS reads.
- rsp_valid with rsp_err=0.
REQ-022 Read cmd addr=0x37; DATA_OUT returns 0x92:
- Writes ADDR=0x37, then CTRL=0x103; DIN is not written.
- rsp_rdata=0x92, rsp_err=0.
REQ-023 awready delayed 5 cycles while wready is immediate: wvalid drops after 1 cycle, awvalid after 6; exactly one B is accepted.
REQ-024 bresp=2'b10 on WR_ADDR: no further AXI traffic; rsp_err=1.
REQ-025 SPI_SEQ_TIMEOUT_EN defined, DONE never set: exactly 1024 STATUS reads, then rsp_err=1.
REQ-026 aresetn pulsed low during POLL; rsp_ready held 0 in RSP for 4 cycles:
- After the reset, IDLE with cmd_ready=1 and no response for the aborted command.
- In RSP, the response holds stable for the 4 cycles.

Source files
------------

// File: rtl/spi_axi_sequencer.sv
// Sequences MFRC522 register accesses over an SPI AXI controller using single-beat AXI4 transfers.
// Optional macro SPI_SEQ_TIMEOUT_EN bounds STATUS polling to 1024 reads.
module spi_axi_sequencer #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [7:0]  OFF_CTRL   = 8'h00,
  parameter logic [7:0]  OFF_STATUS = 8'h04,
  parameter logic [7:0]  OFF_ADDR   = 8'h08,
  parameter logic [7:0]  OFF_DIN    = 8'h0C,
  parameter logic [7:0]  OFF_DOUT   = 8'h10,
  parameter int          DONE_BIT   = 0
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [5:0]  cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [3:0]  m_axi_awid,
  output logic [31:0] m_axi_awaddr,
  output logic [7:0]  m_axi_awlen,
  output logic [2:0]  m_axi_awsize,
  output logic [1:0]  m_axi_awburst,
  output logic [3:0]  m_axi_awcache,
  output logic [2:0]  m_axi_awprot,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wlast,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [3:0]  m_axi_bid,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [3:0]  m_axi_arid,
  output logic [31:0] m_axi_araddr,
  output logic [7:0]  m_axi_arlen,
  output logic [2:0]  m_axi_arsize,
  output logic [1:0]  m_axi_arburst,
  output logic [3:0]  m_axi_arcache,
  output logic [2:0]  m_axi_arprot,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [3:0]  m_axi_rid,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rlast,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_ADDR = 3'd1;
  localparam logic [2:0] S_WR_DIN  = 3'd2;
  localparam logic [2:0] S_WR_CTRL = 3'd3;
  localparam logic [2:0] S_POLL    = 3'd4;
  localparam logic [2:0] S_RD_DOUT = 3'd5;
  localparam logic [2:0] S_RSP     = 3'd6;

  logic [2:0] state;
  logic       rw_q;
  logic [5:0] addr_q;
  logic [7:0] wdata_q;
  logic       b_hs;
  logic       r_hs;
  logic       poll_timeout;

`ifdef SPI_SEQ_TIMEOUT_EN
  logic [9:0] poll_cnt;
  assign poll_timeout = (poll_cnt == 10'h3FF);
`else
  assign poll_timeout = 1'b0;
`endif

  assign b_hs      = m_axi_bvalid & m_axi_bready;
  assign r_hs      = m_axi_rvalid & m_axi_rready;
  assign cmd_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RSP);

  assign m_axi_awid    = 4'd0;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = 3'd2;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awcache = 4'd0;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wlast   = 1'b1;
  assign m_axi_arid    = 4'd0;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = 3'd2;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arcache = 4'd0;
  assign m_axi_arprot  = 3'd0;

  logic unused_inputs;
  assign unused_inputs = ^{m_axi_bid, m_axi_rid, m_axi_rlast, m_axi_rdata};

  // Address and data follow the current step, so a relaunch only needs the valids.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    m_axi_awaddr = BASE_ADDR + {24'd0, OFF_ADDR};
    m_axi_wdata  = {26'd0, addr_q};
    m_axi_araddr = BASE_ADDR + {24'd0, OFF_STATUS};
    case (state)
      S_WR_DIN: begin
        m_axi_awaddr = BASE_ADDR + {24'd0, OFF_DIN};
        m_axi_wdata  = {24'd0, wdata_q};
      end
      S_WR_CTRL: begin
        m_axi_awaddr = BASE_ADDR + {24'd0, OFF_CTRL};
        m_axi_wdata  = 32'h0000_0101 | {30'd0, rw_q, 1'b0};
      end
      S_RD_DOUT: m_axi_araddr = BASE_ADDR + {24'd0, OFF_DOUT};
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; later assignments in the
  // same cycle deliberately override earlier ones (e.g. relaunch after a drop).
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= S_IDLE;
      rw_q          <= 1'b0;
      addr_q        <= 6'd0;
      wdata_q       <= 8'd0;
      rsp_rdata     <= 8'd0;
      rsp_err       <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
      poll_cnt      <= 10'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            rw_q          <= cmd_rw;
            addr_q        <= cmd_addr;
            wdata_q       <= cmd_wdata;
            rsp_rdata     <= 8'd0;
            rsp_err       <= 1'b0;
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            m_axi_bready  <= 1'b1;
            state         <= S_WR_ADDR;
          end
        end
        S_WR_ADDR, S_WR_DIN, S_WR_CTRL: begin
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
          if (b_hs) begin
            m_axi_bready  <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            if (m_axi_bresp != 2'b00) begin
              rsp_err <= 1'b1;
              state   <= S_RSP;
            end else if (state == S_WR_CTRL) begin
              m_axi_arvalid <= 1'b1;
              state         <= S_POLL;
`ifdef SPI_SEQ_TIMEOUT_EN
              poll_cnt      <= 10'd0;
`endif
            end else begin
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              m_axi_bready  <= 1'b1;
              state <= (state == S_WR_ADDR && !rw_q) ? S_WR_DIN : S_WR_CTRL;
            end
          end
        end
        S_POLL, S_RD_DOUT: begin
          if (m_axi_arvalid && m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
          end
          if (r_hs) begin
            m_axi_rready <= 1'b0;
            if (m_axi_rresp != 2'b00) begin
              rsp_err <= 1'b1;
              state   <= S_RSP;
            end else if (state == S_RD_DOUT) begin
              rsp_rdata <= m_axi_rdata[7:0];
              state     <= S_RSP;
            end else if (m_axi_rdata[DONE_BIT]) begin
              m_axi_arvalid <= rw_q;
              state         <= rw_q ? S_RD_DOUT : S_RSP;
            end else if (poll_timeout) begin
              rsp_err <= 1'b1;
              state   <= S_RSP;
            end else begin
              // Reissue STATUS right away: no idle cycle between polls.
              m_axi_arvalid <= 1'b1;
`ifdef SPI_SEQ_TIMEOUT_EN
              poll_cnt      <= poll_cnt + 10'd1;
`endif
            end
          end
        end
        S_RSP:   if (rsp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_axi_sequencer.sv
// Randomized bench for spi_axi_sequencer: a behavioural AXI slave logs traffic and a
// command-level model predicts the register accesses and the response.
module tb_spi_axi_sequencer;

  localparam logic [31:0] A_CTRL   = 32'h00;
  localparam logic [31:0] A_STATUS = 32'h04;
  localparam logic [31:0] A_ADDR   = 32'h08;
  localparam logic [31:0] A_DIN    = 32'h0C;
  localparam logic [31:0] A_DOUT   = 32'h10;
  localparam int          DONE     = 0;

  logic        aclk, aresetn;
  logic        cmd_valid, cmd_ready, cmd_rw;
  logic [5:0]  cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [7:0]  rsp_rdata;
  logic [3:0]  m_axi_awid, m_axi_awcache, m_axi_arid, m_axi_arcache, m_axi_wstrb, m_axi_bid, m_axi_rid;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [7:0]  m_axi_awlen, m_axi_arlen;
  logic [2:0]  m_axi_awsize, m_axi_awprot, m_axi_arsize, m_axi_arprot;
  logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

  spi_axi_sequencer dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awcache(m_axi_awcache),
    .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arcache(m_axi_arcache),
    .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks, n_errors;

  // Slave configuration (written by tests only); -1 latency means random 0..3.
  int          aw_lat_cfg, w_lat_cfg, ar_lat_cfg;
  int          done_after;
  logic [7:0]  dout_val;
  bit          berr_en, rerr_en;
  logic [31:0] berr_addr, rerr_addr;

  // Slave state and traffic logs (written by the slave process only).
  logic [31:0] aw_q[$], w_q[$], ar_q[$];
  logic [31:0] wa_log[$], wd_log[$], ra_log[$];
  int          b_cnt, overlap_cnt, fixed_bad;
  int          aw_wait, w_wait, ar_wait, aw_lat, w_lat, ar_lat, polls_since;
  bit          aw_hs, w_hs, b_hs, ar_hs, r_hs;

  function automatic int pick_lat(input int cfg);
    return (cfg < 0) ? int'($urandom_range(0, 3)) : cfg;
  endfunction

  always begin
    @(posedge aclk);
    aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
    if (aresetn) begin
      if (m_axi_awvalid && m_axi_awready) begin
        aw_q.push_back(m_axi_awaddr); aw_hs = 1;
        if (m_axi_awid != 0 || m_axi_awlen != 0 || m_axi_awsize != 3'd2 || m_axi_awburst != 2'b01 ||
            m_axi_awcache != 0 || m_axi_awprot != 0) fixed_bad++;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        w_q.push_back(m_axi_wdata); w_hs = 1;
        if (m_axi_wstrb != 4'hF || m_axi_wlast != 1'b1) fixed_bad++;
      end
      if (m_axi_bvalid && m_axi_bready) begin b_hs = 1; b_cnt++; end
      if (m_axi_arvalid && m_axi_arready) begin
        ar_q.push_back(m_axi_araddr); ar_hs = 1;
        if (m_axi_arid != 0 || m_axi_arlen != 0 || m_axi_arsize != 3'd2 || m_axi_arburst != 2'b01 ||
            m_axi_arcache != 0 || m_axi_arprot != 0) fixed_bad++;
      end
      if (m_axi_rvalid && m_axi_rready) r_hs = 1;
      if (m_axi_arvalid && (m_axi_awvalid || m_axi_wvalid || m_axi_bready)) overlap_cnt++;
      if (m_axi_awvalid && (m_axi_rready || m_axi_arvalid)) overlap_cnt++;
    end
    @(negedge aclk);
    if (!aresetn) begin
      aw_q.delete(); w_q.delete(); ar_q.delete();
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
      m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rresp = 0; m_axi_rdata = 0;
      aw_wait = 0; w_wait = 0; ar_wait = 0; polls_since = 0;
    end else begin
      if (aw_hs) begin m_axi_awready = 0; aw_wait = 0; end
      else if (m_axi_awvalid) begin
        if (aw_wait == 0) aw_lat = pick_lat(aw_lat_cfg);
        m_axi_awready = (aw_wait >= aw_lat); aw_wait++;
      end else m_axi_awready = 0;
      if (w_hs) begin m_axi_wready = 0; w_wait = 0; end
      else if (m_axi_wvalid) begin
        if (w_wait == 0) w_lat = pick_lat(w_lat_cfg);
        m_axi_wready = (w_wait >= w_lat); w_wait++;
      end else m_axi_wready = 0;
      if (ar_hs) begin m_axi_arready = 0; ar_wait = 0; end
      else if (m_axi_arvalid) begin
        if (ar_wait == 0) ar_lat = pick_lat(ar_lat_cfg);
        m_axi_arready = (ar_wait >= ar_lat); ar_wait++;
      end else m_axi_arready = 0;
      if (b_hs) m_axi_bvalid = 0;
      else if (!m_axi_bvalid && aw_q.size() > 0 && w_q.size() > 0) begin
        logic [31:0] a;
        a = aw_q.pop_front();
        wa_log.push_back(a); wd_log.push_back(w_q.pop_front());
        if (a == A_CTRL) polls_since = 0;  // a CTRL write starts a new SPI transfer
        m_axi_bresp  = (berr_en && a == berr_addr) ? 2'b10 : 2'b00;
        m_axi_bvalid = 1;
      end
      if (r_hs) m_axi_rvalid = 0;
      else if (!m_axi_rvalid && ar_q.size() > 0) begin
        logic [31:0] a, d;
        a = ar_q.pop_front();
        ra_log.push_back(a);
        d = $urandom;
        if (a == A_STATUS) begin
          polls_since++;
          d[DONE] = (done_after != 0 && polls_since >= done_after);
        end else d[7:0] = dout_val;
        m_axi_rdata  = d;
        m_axi_rresp  = (rerr_en && a == rerr_addr) ? 2'b10 : 2'b00;
        m_axi_rvalid = 1;
      end
    end
  end

  // Runs one command and scores it against the command-level model.
  task automatic do_command(input string name, input bit rw, input logic [5:0] addr,
                            input logic [7:0] wdata, input int n_polls, input logic [7:0] dout,
                            input int hold, input int limit, output int aw_high, output int w_high);
    logic [31:0] exp_wa[$], exp_wd[$], exp_ra[$];
    bit          exp_err;
    logic [7:0]  exp_rd, got_rd;
    logic        got_err;
    int          wa0, ra0, b0, cyc, polls;
    exp_err = 0;
    exp_wa.push_back(A_ADDR); exp_wd.push_back({26'd0, addr});
    if (!rw) begin exp_wa.push_back(A_DIN); exp_wd.push_back({24'd0, wdata}); end
    exp_wa.push_back(A_CTRL); exp_wd.push_back(rw ? 32'h103 : 32'h101);
    for (int i = 0; i < exp_wa.size(); i++)
      if (berr_en && exp_wa[i] == berr_addr) begin
        exp_err = 1;
        while (exp_wa.size() > i + 1) begin void'(exp_wa.pop_back()); void'(exp_wd.pop_back()); end
        break;
      end
    if (!exp_err) begin
      polls = (n_polls == 0) ? 1024 : n_polls;
      for (int p = 0; p < polls; p++) begin
        exp_ra.push_back(A_STATUS);
        if (rerr_en && rerr_addr == A_STATUS) begin exp_err = 1; break; end
      end
      if (n_polls == 0) exp_err = 1;
      if (!exp_err && rw) exp_ra.push_back(A_DOUT);
    end
    exp_rd = (rw && !exp_err) ? dout : 8'h00;

    done_after = n_polls; dout_val = dout;
    wa0 = wa_log.size(); ra0 = ra_log.size(); b0 = b_cnt;
    aw_high = 0; w_high = 0;
    @(negedge aclk);
    n_checks++;
    if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL %s idle cmd_ready: got %b want 1", name, cmd_ready); end
    cmd_valid = 1; cmd_rw = rw; cmd_addr = addr; cmd_wdata = wdata;
    @(negedge aclk);
    cmd_valid = 0; cmd_rw = $urandom; cmd_addr = $urandom; cmd_wdata = $urandom;
    cyc = 0;
    while (!rsp_valid && cyc < limit) begin
      if (b_cnt == b0) begin
        if (m_axi_awvalid) aw_high++;
        if (m_axi_wvalid)  w_high++;
      end
      @(negedge aclk); cyc++;
    end
    n_checks++;
    if (!rsp_valid) begin
      n_errors++; $display("FAIL %s rsp_valid: got 0 after %0d cycles want 1", name, limit);
      return;
    end
    got_rd = rsp_rdata; got_err = rsp_err;
    n_checks++;
    if (got_rd !== exp_rd) begin n_errors++; $display("FAIL %s rsp_rdata: got %h want %h", name, got_rd, exp_rd); end
    n_checks++;
    if (got_err !== exp_err) begin n_errors++; $display("FAIL %s rsp_err: got %b want %b", name, got_err, exp_err); end
    for (int i = 0; i < hold; i++) begin
      @(negedge aclk);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== got_rd || rsp_err !== got_err) begin
        n_errors++;
        $display("FAIL %s hold cycle %0d: got v=%b d=%h e=%b want v=1 d=%h e=%b",
                 name, i, rsp_valid, rsp_rdata, rsp_err, got_rd, got_err);
      end
    end
    rsp_ready = 1;
    @(negedge aclk);
    rsp_ready = 0;
    n_checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_errors++; $display("FAIL %s return to idle: got rsp_valid=%b cmd_ready=%b want 0/1", name, rsp_valid, cmd_ready);
    end
    n_checks++;
    if (wa_log.size() - wa0 != exp_wa.size() || b_cnt - b0 != exp_wa.size()) begin
      n_errors++; $display("FAIL %s write count: got %0d (B %0d) want %0d", name, wa_log.size() - wa0, b_cnt - b0, exp_wa.size());
    end else
      for (int i = 0; i < exp_wa.size(); i++) begin
        n_checks++;
        if (wa_log[wa0+i] !== exp_wa[i] || wd_log[wa0+i] !== exp_wd[i]) begin
          n_errors++; $display("FAIL %s write %0d: got %h=%h want %h=%h", name, i,
                               wa_log[wa0+i], wd_log[wa0+i], exp_wa[i], exp_wd[i]);
        end
      end
    n_checks++;
    if (ra_log.size() - ra0 != exp_ra.size()) begin
      n_errors++; $display("FAIL %s read count: got %0d want %0d", name, ra_log.size() - ra0, exp_ra.size());
    end else
      for (int i = 0; i < exp_ra.size(); i++)
        if (ra_log[ra0+i] !== exp_ra[i]) begin
          n_checks++; n_errors++;
          $display("FAIL %s read %0d: got %h want %h", name, i, ra_log[ra0+i], exp_ra[i]);
        end
  endtask

  task automatic test_reset();
    aresetn = 0;
    repeat (3) @(negedge aclk);
    n_checks++;
    if ({cmd_ready, rsp_valid, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 7'b1000000) begin
      n_errors++; $display("FAIL reset handshakes: got %b want 1000000",
        {cmd_ready, rsp_valid, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready});
    end
    n_checks++;
    if (rsp_rdata !== 8'h00 || rsp_err !== 1'b0) begin
      n_errors++; $display("FAIL reset response: got rdata=%h err=%b want 00/0", rsp_rdata, rsp_err);
    end
    @(posedge aclk); #1 aresetn = 1;
  endtask

  task automatic test_write_basic();
    int a, w;
    do_command("write_basic", 1'b0, 6'h0C, 8'h10, 3, 8'h00, 0, 500, a, w);
  endtask

  task automatic test_read_basic();
    int a, w;
    do_command("read_basic", 1'b1, 6'h37, 8'h5A, 2, 8'h92, 0, 500, a, w);
  endtask

  task automatic test_aw_delay();
    int a, w;
    aw_lat_cfg = 5; w_lat_cfg = 0;
    do_command("aw_delay", 1'b0, 6'h21, 8'hC3, 1, 8'h00, 0, 500, a, w);
    n_checks++;
    if (a != 6 || w != 1) begin
      n_errors++; $display("FAIL aw_delay valid widths: got aw=%0d w=%0d want aw=6 w=1", a, w);
    end
    aw_lat_cfg = -1; w_lat_cfg = -1;
  endtask

  task automatic test_bresp_err();
    int a, w;
    berr_en = 1; berr_addr = A_ADDR;
    do_command("bresp_err", 1'b0, 6'h0C, 8'h10, 3, 8'h00, 0, 500, a, w);
    berr_en = 1; berr_addr = A_CTRL;
    do_command("bresp_err_ctrl", 1'b1, 6'h11, 8'h00, 2, 8'h44, 0, 500, a, w);
    berr_en = 0;
  endtask

  task automatic test_rresp_err();
    int a, w;
    rerr_en = 1; rerr_addr = A_STATUS;
    do_command("rresp_err", 1'b1, 6'h05, 8'h00, 3, 8'h77, 0, 500, a, w);
    rerr_en = 0;
  endtask

  task automatic test_back_to_back();
    int a, w;
    for (int i = 0; i < 20; i++)
      do_command($sformatf("b2b_%0d", i), 1'($urandom), 6'($urandom), 8'($urandom),
                 int'($urandom_range(1, 5)), 8'($urandom), 0, 1000, a, w);
  endtask

  task automatic test_reset_mid_poll();
    int ra0, cyc, seen_rsp, a, w;
    done_after = 0;
    ra0 = ra_log.size();
    @(negedge aclk);
    cmd_valid = 1; cmd_rw = 1; cmd_addr = 6'h2A; cmd_wdata = 8'h00;
    @(negedge aclk);
    cmd_valid = 0;
    cyc = 0;
    while (ra_log.size() < ra0 + 2 && cyc < 500) begin @(negedge aclk); cyc++; end
    n_checks++;
    if (ra_log.size() < ra0 + 2) begin n_errors++; $display("FAIL reset_mid_poll reach POLL: got %0d reads want 2", ra_log.size() - ra0); end
    aresetn = 0;
    #1;
    n_checks++;
    if ({m_axi_arvalid, m_axi_rready, cmd_ready} !== 3'b001) begin
      n_errors++; $display("FAIL reset_mid_poll async clear: got ar/r/cmd_ready=%b want 001", {m_axi_arvalid, m_axi_rready, cmd_ready});
    end
    repeat (2) @(posedge aclk);
    #1 aresetn = 1;
    seen_rsp = 0;
    for (int i = 0; i < 20; i++) begin @(negedge aclk); if (rsp_valid) seen_rsp++; end
    n_checks++;
    if (seen_rsp != 0 || cmd_ready !== 1'b1) begin
      n_errors++; $display("FAIL reset_mid_poll aftermath: got rsp cycles=%0d cmd_ready=%b want 0/1", seen_rsp, cmd_ready);
    end
    do_command("rsp_hold", 1'b1, 6'h3F, 8'h00, 2, 8'hA5, 4, 500, a, w);
  endtask

`ifdef SPI_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int a, w;
    do_command("timeout", 1'b1, 6'h01, 8'h00, 0, 8'h99, 0, 20000, a, w);
  endtask
`endif

  task automatic test_protocol();
    n_checks++;
    if (overlap_cnt != 0) begin n_errors++; $display("FAIL protocol overlap: got %0d want 0", overlap_cnt); end
    n_checks++;
    if (fixed_bad != 0) begin n_errors++; $display("FAIL protocol fixed fields: got %0d bad want 0", fixed_bad); end
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    aw_lat_cfg = -1; w_lat_cfg = -1; ar_lat_cfg = -1;
    done_after = 1; dout_val = 0; berr_en = 0; rerr_en = 0; berr_addr = 0; rerr_addr = 0;
    aresetn = 0; cmd_valid = 0; cmd_rw = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 0;
    m_axi_bid = 0; m_axi_rid = 0; m_axi_rlast = 1;
    test_reset();
    test_write_basic();
    test_read_basic();
    test_aw_delay();
    test_bresp_err();
    test_rresp_err();
    test_back_to_back();
    test_reset_mid_poll();
`ifdef SPI_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_protocol();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
